// File: rtl/load_store_unit.sv
// load_store_unit: RV32 byte/half/word load-store front end for a word-wide DataMemory without byte enables.
// Latency from accepting edge E0: load resp after E2, SW after E1, SB/SH (read-modify-write) after E3, error after E0.
// Backpressure: req_ready only in IDLE; one request in flight, requester holds req_valid until accepted.
// Ports: clk/rst_n; req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata in;
//        resp_valid/resp_rdata/resp_err out; mem_rd/mem_wd/mem_size/mem_addr/mem_data_in out, mem_data_out in.
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W and funct3 011/110/111 with resp_err;
// otherwise misaligned low address bits are ignored and 011/110/111 behave as W.
module load_store_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_rd,
    output logic                    mem_wd,
    output logic [1:0]              mem_size,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data_in,
    input  logic [DATA_WIDTH-1:0]   mem_data_out
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_WRITE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic                    uns_q, uns_d;
    logic [1:0]              lane_q, lane_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]              mem_size_q, mem_size_d;
    logic [DATA_WIDTH-1:0]   mem_data_in_q, mem_data_in_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    err_q, err_d;

    logic [1:0]              req_size;
    logic                    req_err;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [DATA_WIDTH-1:0]   merged;

    // Size code from funct3[1:0]: 00 byte, 01 half, anything else word.
    assign req_size = (req_funct3[1:0] == 2'b00) ? 2'b00 :
                      (req_funct3[1:0] == 2'b01) ? 2'b01 : 2'b10;

`ifdef MISALIGN_TRAP_EN
    assign req_err = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign req_err = 1'b0;
`endif

    // Lane extraction: half lanes only look at lane bit 1, so misaligned halves
    // silently snap down to the aligned half when trapping is disabled.
    assign byte_v = mem_data_out[{lane_q, 3'b000} +: 8];
    assign half_v = mem_data_out[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        load_val = mem_data_out;
        case (mem_size_q)
            2'b00:   load_val = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_val = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_val = mem_data_out;
        endcase
    end

    // Sub-word store merge: untouched bytes come straight from the read word.
    always_comb begin
        merged = mem_data_out;
        case (mem_size_q)
            2'b00:   merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        uns_d         = uns_q;
        lane_d        = lane_q;
        wdata_d       = wdata_q;
        mem_addr_d    = mem_addr_q;
        mem_size_d    = mem_size_q;
        mem_data_in_d = mem_data_in_q;
        resp_rdata_d  = resp_rdata_q;
        err_d         = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    uns_d      = req_funct3[2];
                    lane_d     = req_addr[1:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = req_addr[ADDR_WIDTH+1:2];
                    mem_size_d = req_size;
                    err_d      = req_err;
                    if (req_err) begin
                        resp_rdata_d = '0;
                        state_d      = S_DONE;
                    end else if (req_we && (req_size == 2'b10)) begin
                        // Full-word store needs no read.
                        mem_data_in_d = req_wdata;
                        state_d       = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = S_CAPT;
            S_CAPT: begin
                if (we_q) begin
                    mem_data_in_d = merged;
                    state_d       = S_WRITE;
                end else begin
                    resp_rdata_d = load_val;
                    state_d      = S_DONE;
                end
            end
            S_WRITE: begin
                resp_rdata_d = '0;
                state_d      = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            lane_q        <= 2'b00;
            wdata_q       <= '0;
            mem_addr_q    <= '0;
            mem_size_q    <= 2'b00;
            mem_data_in_q <= '0;
            resp_rdata_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            uns_q         <= uns_d;
            lane_q        <= lane_d;
            wdata_q       <= wdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_size_q    <= mem_size_d;
            mem_data_in_q <= mem_data_in_d;
            resp_rdata_q  <= resp_rdata_d;
            err_q         <= err_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign resp_err    = resp_valid & err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_rd      = (state_q == S_READ);
    assign mem_wd      = (state_q == S_WRITE);
    assign mem_size    = mem_size_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset-abort and back-to-back sequences,
// then random traffic against a byte-array reference model.
module tb_load_store_unit;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_rd, mem_wd;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd(mem_rd), .mem_wd(mem_wd), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // DataMemory: 64 words, registered read; memory is cleared while mem_clr is high.
    logic [31:0] tb_mem [0:63];
    logic        mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= '0;
            mem_data_out <= '0;
        end else begin
            if (mem_rd) mem_data_out <= tb_mem[mem_addr[5:0]];
            if (mem_wd) tb_mem[mem_addr[5:0]] <= mem_data_in;
        end
    end

    // Reference: plain byte-addressed memory.
    logic [7:0] ref_mem [0:255];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic ref_apply(input logic we, input logic [2:0] f3, input logic [AW+1:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd, output logic err,
                             output int lat, output logic [1:0] szc, output int nrd, output int nwd);
        int size, base;
        logic [31:0] v;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        szc  = (size == 1) ? 2'd0 : (size == 2) ? 2'd1 : 2'd2;
        err  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) err = 1'b1;
        else if (size == 2 && addr[0]) err = 1'b1;
        else if (size == 4 && addr[1:0] != 2'b00) err = 1'b1;
`endif
        base = (int'(addr) & ~(size - 1)) & 255;
        rd = '0; nrd = 0; nwd = 0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
            lat = (size == 4) ? 2 : 4;
            nrd = (size == 4) ? 0 : 1;
            nwd = 1;
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
            if (size == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
            if (size == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
            rd = v; lat = 3; nrd = 1;
        end
    endtask

    // Issue one request, count cycles (negedges) until resp_valid, monitor memory strobes.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW+1:0] addr,
                          input logic [31:0] wd, input logic [1:0] exp_szc,
                          output logic [31:0] rd, output logic e, output int lat,
                          output int nrd, output int nwd);
        int guard;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble request inputs: the unit must have captured them already.
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = (AW+2)'($urandom); req_wdata = $urandom;
        lat = 1; nrd = 0; nwd = 0;
        while (!resp_valid && lat < 20) begin
            if (mem_rd) nrd++;
            if (mem_wd) nwd++;
            if (mem_rd || mem_wd) begin
                chk("mem_addr", 32'(mem_addr), 32'(addr[AW+1:2]));
                chk("mem_size", 32'(mem_size), 32'(exp_szc));
                chk("rd_wd_excl", 32'(mem_rd & mem_wd), 32'd0);
            end
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata; e = resp_err;
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        logic          we;
        logic [2:0]    f3;
        logic [AW+1:0] addr;
        logic [31:0]   wd;
        logic [31:0]   exp_rd;
        logic          exp_err;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [31:0] rd, erd;
        logic        e, eerr;
        int          lat, elat, nrd, nwd, enrd, enwd, k, first_ready, resp_at, cnt_wd, cnt_rv;
        logic [1:0]  szc;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        rst_n = 1'b0;

        tbl[0]  = '{1'b1, 3'd2, 18'h10, 32'hDEADBEEF, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 3'd2, 18'h10, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 3'd2, 18'h20, 32'h11223344, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 3'd0, 18'h21, 32'h123456AA, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 3'd2, 18'h20, 32'h0, 32'h1122AA44, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 18'h21, 32'h0, 32'hFFFFFFAA, 1'b0};
        tbl[6]  = '{1'b0, 3'd4, 18'h21, 32'h0, 32'h000000AA, 1'b0};
        tbl[7]  = '{1'b1, 3'd1, 18'h22, 32'hCAFE8001, 32'h0, 1'b0};
        tbl[8]  = '{1'b0, 3'd2, 18'h20, 32'h0, 32'h8001AA44, 1'b0};
        tbl[9]  = '{1'b0, 3'd1, 18'h22, 32'h0, 32'hFFFF8001, 1'b0};
        tbl[10] = '{1'b0, 3'd5, 18'h22, 32'h0, 32'h00008001, 1'b0};
`ifdef MISALIGN_TRAP_EN
        tbl[11] = '{1'b0, 3'd2, 18'h13, 32'h0, 32'h0, 1'b1};
        tbl[12] = '{1'b0, 3'd1, 18'h21, 32'h0, 32'h0, 1'b1};
        tbl[13] = '{1'b0, 3'd3, 18'h20, 32'h0, 32'h0, 1'b1};
`else
        tbl[11] = '{1'b0, 3'd2, 18'h13, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[12] = '{1'b0, 3'd1, 18'h21, 32'h0, 32'hFFFFAA44, 1'b0};
        tbl[13] = '{1'b0, 3'd3, 18'h20, 32'h0, 32'h8001AA44, 1'b0};
`endif
        tbl[14] = '{1'b0, 3'd0, 18'h23, 32'h0, 32'hFFFFFF80, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wd", 32'(mem_wd), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data_in", mem_data_in, 32'd0);
        chk("rst_mem_size", 32'(mem_size), 32'd0);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            ref_apply(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, erd, eerr, elat, szc, enrd, enwd);
            do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, szc, rd, e, lat, nrd, nwd);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(elat));
            chk($sformatf("tbl%0d_nrd", i), 32'(nrd), 32'(enrd));
            chk($sformatf("tbl%0d_nwd", i), 32'(nwd), 32'(enwd));
        end

        // Reset in the READ state of an SB: request dropped, memory untouched.
        req_we = 1'b1; req_funct3 = 3'd0; req_addr = 18'h20; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_read", 32'(mem_rd), 32'd1);
        #1 rst_n = 1'b0; req_valid = 1'b0;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_mem_rd", 32'(mem_rd), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        cnt_wd = 0; cnt_rv = 0;
        repeat (2) begin @(negedge clk); if (mem_wd) cnt_wd++; if (resp_valid) cnt_rv++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (mem_wd) cnt_wd++; if (resp_valid) cnt_rv++; end
        chk("abort_no_write", 32'(cnt_wd), 32'd0);
        chk("abort_no_resp", 32'(cnt_rv), 32'd0);
        chk("abort_mem_word", tb_mem[8], 32'h8001AA44);

        // Back-to-back: LW held valid during a busy SB.
        ref_apply(1'b1, 3'd0, 18'h20, 32'h5A, erd, eerr, elat, szc, enrd, enwd);
        req_we = 1'b1; req_funct3 = 3'd0; req_addr = 18'h20; req_wdata = 32'h5A; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 18'h20; req_wdata = 32'h0;
        k = 1; first_ready = -1; resp_at = -1;
        while (k < 20 && first_ready < 0) begin
            if (resp_valid) resp_at = k;
            if (req_ready) first_ready = k;
            else begin @(negedge clk); k++; end
        end
        chk("b2b_ready_cycle", 32'(first_ready), 32'd5);
        chk("b2b_sb_resp_cycle", 32'(resp_at), 32'd4);
        ref_apply(1'b0, 3'd2, 18'h20, 32'h0, erd, eerr, elat, szc, enrd, enwd);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!resp_valid && k < 20) begin @(negedge clk); k++; end
        chk("b2b_lw_lat", 32'(k), 32'd3);
        chk("b2b_lw_rdata", resp_rdata, erd);
        @(negedge clk);

        // Random traffic vs reference model
        for (int n = 0; n < 300; n++) begin
            logic          rwe;
            logic [2:0]    rf3;
            logic [AW+1:0] raddr;
            logic [31:0]   rwd;
            rwe   = 1'($urandom);
            rf3   = rwe ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            raddr = (AW+2)'($urandom_range(0, 255));
            rwd   = $urandom;
            ref_apply(rwe, rf3, raddr, rwd, erd, eerr, elat, szc, enrd, enwd);
            do_req(rwe, rf3, raddr, rwd, szc, rd, e, lat, nrd, nwd);
            chk("rnd_rdata", rd, erd);
            chk("rnd_err", 32'(e), 32'(eerr));
            chk("rnd_lat", 32'(lat), 32'(elat));
            chk("rnd_nrd", 32'(nrd), 32'(enrd));
            chk("rnd_nwd", 32'(nwd), 32'(enwd));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
